// File: rtl/arb_pkt_mux.sv
// Packet-level mux behind a round-robin arbiter: latches the granted channel on a packet's
// first beat and holds it until the last beat is accepted, feeding one registered output stream.
module arb_pkt_mux #(
    parameter int WID     = 16,
    parameter int DAT_WID = 32,
    parameter int CNT_WID = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WID-1:0]         in_vld,
    input  logic [WID*DAT_WID-1:0] in_dat,
    input  logic [WID-1:0]         in_lst,
    output logic [WID-1:0]         in_rdy,
    output logic [WID-1:0]         arb_rqsts,
    input  logic [WID-1:0]         arb_grnts,
    output logic                   out_vld,
    output logic [DAT_WID-1:0]     out_dat,
    output logic                   out_lst,
    input  logic                   out_rdy,
    output logic                   busy,
    output logic [WID-1:0]         lock_chn,
    output logic [CNT_WID-1:0]     pkt_cnt,
    output logic                   err_gnt
);

    // state  | meaning
    // S_IDLE | no packet open; first beat of next packet follows the arbiter grant
    // S_LOCK | packet open on r_lock_chn; grants ignored until its last beat is accepted
    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t               r_state;
    state_t               w_nxt_state;
    logic [WID-1:0]       r_lock_chn;
    logic                 r_out_vld;
    logic [DAT_WID-1:0]   r_out_dat;
    logic                 r_out_lst;
    logic [CNT_WID-1:0]   r_pkt_cnt;
    logic                 r_err_gnt;

    logic                 w_can_acc;
    logic                 w_gnt_onehot;
    logic                 w_gnt_legal;
    logic [WID-1:0]       w_sel;
    logic                 w_xfer;
    logic                 w_err;
    logic [DAT_WID-1:0]   w_dat;
    logic                 w_lst;

    assign w_can_acc    = !r_out_vld || out_rdy;
    assign w_gnt_onehot = (arb_grnts != '0) && ((arb_grnts & (arb_grnts - WID'(1))) == '0);
    assign w_gnt_legal  = w_gnt_onehot && ((arb_grnts & in_vld) != '0);

    always_comb begin
        w_nxt_state = r_state;
        arb_rqsts   = in_vld;
        in_rdy      = '0;
        w_sel       = '0;
        w_xfer      = 1'b0;
        w_err       = 1'b0;
        w_dat       = '0;
        w_lst       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_gnt_legal) begin
                    w_sel  = arb_grnts;
                    in_rdy = arb_grnts & {WID{w_can_acc}};
                    w_xfer = w_can_acc;
                end else if (arb_grnts != '0) begin
                    w_err = 1'b1;
                end
            end
            S_LOCK: begin
                arb_rqsts = r_lock_chn & in_vld;
                w_sel     = r_lock_chn;
                in_rdy    = r_lock_chn & {WID{w_can_acc}};
                w_xfer    = ((r_lock_chn & in_vld) != '0) && w_can_acc;
            end
            default: w_nxt_state = S_IDLE;
        endcase

        // w_sel is one-hot or zero, so OR-ing the selected lanes is a plain mux
        for (int i = 0; i < WID; i++) begin
            if (w_sel[i]) begin
                w_dat = w_dat | in_dat[i*DAT_WID +: DAT_WID];
                w_lst = w_lst | in_lst[i];
            end
        end

        if (w_xfer) begin
            if (r_state == S_IDLE && !w_lst) begin
                w_nxt_state = S_LOCK;
            end else if (r_state == S_LOCK && w_lst) begin
                w_nxt_state = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lock_chn <= '0;
            r_pkt_cnt  <= '0;
            r_err_gnt  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (w_xfer) begin
                if (r_state == S_IDLE && !w_lst) begin
                    r_lock_chn <= w_sel;
                end else if (r_state == S_LOCK && w_lst) begin
                    r_lock_chn <= '0;
                end
                if (w_lst) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_WID'(1);
                end
            end
            if (w_err) begin
                r_err_gnt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_lst <= 1'b0;
        end else if (w_xfer) begin
            r_out_vld <= 1'b1;
            r_out_dat <= w_dat;
            r_out_lst <= w_lst;
        end else if (out_rdy) begin
            r_out_vld <= 1'b0;
        end
    end

    assign out_vld  = r_out_vld;
    assign out_dat  = r_out_dat;
    assign out_lst  = r_out_lst;
    assign busy     = (r_state == S_LOCK);
    assign lock_chn = r_lock_chn;
    assign pkt_cnt  = r_pkt_cnt;
    assign err_gnt  = r_err_gnt;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed bench: two muxes (16-bit and 2-bit packet counters) share one set of sources
// and a round-robin grant model that can be overridden to inject arbitrary grants.
module tb_arb_pkt_mux;

    localparam int WID = 4;
    localparam int DW  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [WID-1:0]  in_vld, in_lst, arb_grnts, arb_model;
    logic [WID*DW-1:0] in_dat;
    logic            out_rdy;

    logic [WID-1:0]  a_rdy, a_rqsts, a_lock;
    logic            a_vld, a_lst, a_busy, a_err;
    logic [DW-1:0]   a_dat;
    logic [15:0]     a_cnt;

    logic [WID-1:0]  b_rdy, b_rqsts, b_lock;
    logic            b_vld, b_lst, b_busy, b_err;
    logic [DW-1:0]   b_dat;
    logic [1:0]      b_cnt;

    int              rem [WID];
    int              beat [WID];
    int              ptr;
    logic            force_en;
    logic [WID-1:0]  gnt_force;
    int              errors = 0;
    int              checks = 0;
    int              vld_cnt;

    always #5 clk = ~clk;

    arb_pkt_mux #(.WID(WID), .DAT_WID(DW), .CNT_WID(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_dat(in_dat), .in_lst(in_lst),
        .in_rdy(a_rdy), .arb_rqsts(a_rqsts), .arb_grnts(arb_grnts),
        .out_vld(a_vld), .out_dat(a_dat), .out_lst(a_lst), .out_rdy(out_rdy),
        .busy(a_busy), .lock_chn(a_lock), .pkt_cnt(a_cnt), .err_gnt(a_err)
    );

    arb_pkt_mux #(.WID(WID), .DAT_WID(DW), .CNT_WID(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_dat(in_dat), .in_lst(in_lst),
        .in_rdy(b_rdy), .arb_rqsts(b_rqsts), .arb_grnts(arb_grnts),
        .out_vld(b_vld), .out_dat(b_dat), .out_lst(b_lst), .out_rdy(out_rdy),
        .busy(b_busy), .lock_chn(b_lock), .pkt_cnt(b_cnt), .err_gnt(b_err)
    );

    always_comb begin
        arb_model = '0;
        for (int k = 0; k < WID; k++) begin
            if (arb_model == '0 && a_rqsts[(ptr + k) % WID]) begin
                arb_model[(ptr + k) % WID] = 1'b1;
            end
        end
    end
    assign arb_grnts = force_en ? gnt_force : arb_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < WID; i++) begin
            in_vld[i] = (rem[i] != 0);
            in_lst[i] = (rem[i] == 1);
            in_dat[i*DW +: DW] = 32'(i * 256 + beat[i]);
        end
    endtask

    task automatic load(input int ch, input int n);
        rem[ch]  = n;
        beat[ch] = 0;
        drive();
        #1;
    endtask

    // one clock: sample handshakes at negedge, update sources just after posedge
    task automatic cyc();
        logic [WID-1:0] acc;
        logic [WID-1:0] g;
        logic           fe;
        @(negedge clk);
        acc = in_vld & a_rdy;
        g   = arb_grnts;
        fe  = force_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < WID; i++) begin
            if (acc[i]) begin
                rem[i]--;
                beat[i]++;
            end
            if (!fe && g[i]) ptr = (i + 1) % WID;
        end
        drive();
        #1;
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        rst_n = 1'b0; out_rdy = 1'b1; force_en = 1'b0; gnt_force = '0; ptr = 0;
        in_vld = '0; in_lst = '0; in_dat = '0;
        for (int i = 0; i < WID; i++) begin rem[i] = 0; beat[i] = 0; end
        drive();
        #3;
        chk("rst_out_vld", 32'(a_vld), 0);
        chk("rst_out_dat", a_dat, 0);
        chk("rst_out_lst", 32'(a_lst), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_lock", 32'(a_lock), 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_err", 32'(a_err), 0);
        #10 rst_n = 1'b1;
        cyc();

        // four 3-beat packets, full throughput, channel order 0..3
        for (int c = 0; c < WID; c++) load(c, 3);
        vld_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (a_vld) vld_cnt++;
            chk($sformatf("rr_dat%0d", k), a_dat, 32'((k / 3) * 256 + (k % 3)));
            chk($sformatf("rr_lst%0d", k), 32'(a_lst), 32'((k % 3) == 2));
            if (k == 0) chk("rr_lock0", 32'(a_lock), 32'b0001);
        end
        chk("rr_vld_run", 32'(vld_cnt), 12);
        chk("rr_cnt", 32'(a_cnt), 4);
        chk("rr_busy_end", 32'(a_busy), 0);
        cyc();
        chk("rr_drain_vld", 32'(a_vld), 0);

        // lock holds channel 1 against a grant to channel 0
        load(1, 4);
        cyc();
        chk("lk_dat0", a_dat, 32'h100);
        chk("lk_lock", 32'(a_lock), 32'b0010);
        load(0, 2);
        force_en = 1'b1; gnt_force = 4'b0001;
        #1;
        chk("lk_rdy", 32'(a_rdy), 32'b0010);
        chk("lk_rqsts", 32'(a_rqsts), 32'b0010);
        cyc();
        chk("lk_dat1", a_dat, 32'h101);
        cyc();
        chk("lk_dat2", a_dat, 32'h102);
        cyc();
        chk("lk_dat3", a_dat, 32'h103);
        chk("lk_lst3", 32'(a_lst), 1);
        chk("lk_busy_off", 32'(a_busy), 0);
        chk("lk_rdy_ch0", 32'(a_rdy), 32'b0001);
        force_en = 1'b0;
        cyc();
        chk("lk_ch0_dat0", a_dat, 32'h000);
        chk("lk_ch0_lock", 32'(a_lock), 32'b0001);
        cyc();
        chk("lk_ch0_dat1", a_dat, 32'h001);
        chk("lk_cnt", 32'(a_cnt), 6);

        // downstream stall for 5 cycles
        load(2, 3);
        cyc();
        chk("st_dat0", a_dat, 32'h200);
        out_rdy = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("st_hold_dat%0d", k), a_dat, 32'h200);
            chk($sformatf("st_hold_vld%0d", k), 32'(a_vld), 1);
            chk($sformatf("st_hold_rdy%0d", k), 32'(a_rdy), 0);
        end
        out_rdy = 1'b1;
        #1;
        chk("st_rel_rdy", 32'(a_rdy), 32'b0100);
        cyc();
        chk("st_dat1", a_dat, 32'h201);
        cyc();
        chk("st_dat2", a_dat, 32'h202);
        chk("st_lst2", 32'(a_lst), 1);
        chk("st_cnt", 32'(a_cnt), 7);
        cyc();
        chk("st_drain_vld", 32'(a_vld), 0);

        // illegal grants
        force_en = 1'b1; gnt_force = 4'b0000;
        #1;
        cyc();
        chk("ig_zero_err", 32'(a_err), 0);
        load(1, 1);
        load(2, 1);
        gnt_force = 4'b0110;
        #1;
        chk("ig_rdy", 32'(a_rdy), 0);
        cyc();
        chk("ig_err", 32'(a_err), 1);
        chk("ig_vld", 32'(a_vld), 0);
        chk("ig_cnt", 32'(a_cnt), 7);
        rem[1] = 0; rem[2] = 0; drive();
        gnt_force = 4'b0000;
        cyc();
        chk("ig_sticky", 32'(a_err), 1);
        force_en = 1'b0;

        // asynchronous reset mid-packet
        load(3, 4);
        cyc();
        chk("ar_dat0", a_dat, 32'h300);
        chk("ar_busy", 32'(a_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", 32'(a_vld), 0);
        chk("ar_busy0", 32'(a_busy), 0);
        chk("ar_lock0", 32'(a_lock), 0);
        chk("ar_cnt0", 32'(a_cnt), 0);
        chk("ar_err0", 32'(a_err), 0);
        rem[3] = 0; drive(); ptr = 0;
        #1 rst_n = 1'b1;
        cyc();
        chk("ar_idle_vld", 32'(a_vld), 0);
        load(2, 1);
        cyc();
        chk("ar_new_vld", 32'(a_vld), 1);
        chk("ar_new_dat", a_dat, 32'h200);
        chk("ar_new_lst", 32'(a_lst), 1);
        chk("ar_new_cnt", 32'(a_cnt), 1);
        chk("ar_new_busy", 32'(a_busy), 0);

        // counter wrap with a 2-bit counter, back-to-back single beats
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        ptr = 0;
        for (int k = 0; k < 5; k++) begin
            load(k % WID, 1);
            cyc();
            chk($sformatf("wr_cnt2_%0d", k), 32'(b_cnt), 32'(wrap_exp[k]));
            chk($sformatf("wr_cnt16_%0d", k), 32'(a_cnt), 32'(k + 1));
            chk($sformatf("wr_dat%0d", k), b_dat, 32'((k % WID) * 256));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
